// File: rtl/ddr3_sched_pkg.sv
// ddr3_sched_pkg: shared state encoding, timing constants and field widths for the DDR3 command scheduler
package ddr3_sched_pkg;

    localparam int ROW_W = 15;
    localparam int COL_W = 10;
    localparam int BA_W  = 3;
    localparam int DQ_W  = 16;

    localparam int T_INIT = 8;
    localparam int T_ZQ   = 16;
    localparam int T_MRD  = 4;
    localparam int T_RCD  = 3;
    localparam int T_WR   = 6;
    localparam int T_RTP  = 4;
    localparam int T_RP   = 3;
    localparam int T_RFC  = 20;
    localparam int T_REFI = 200;

    localparam int CNT_W  = 8;
    localparam int REFI_W = 8;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_ZQ,
        ST_ZQ_WAIT,
        ST_MRS,
        ST_MRS_WAIT,
        ST_IDLE,
        ST_REFRESH,
        ST_RFC_WAIT,
        ST_ACTIVATE,
        ST_RCD_WAIT,
        ST_RW,
        ST_RW_WAIT,
        ST_PRECHARGE,
        ST_RP_WAIT
    } state_t;

    // Wait counter value loaded in a strobe state so the next step lands exactly t cycles later
    function automatic logic [CNT_W-1:0] ld(input int t);
        return CNT_W'(t - 1);
    endfunction

endpackage

// File: rtl/ddr3_refresh_timer.sv
// ddr3_refresh_timer: T_REFI down-counter armed on first IDLE entry, reloaded on REF, flags refresh_pending at zero
module ddr3_refresh_timer
    import ddr3_sched_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic arm_i,
    input  logic ref_i,
    output logic pending_o
);

    logic [REFI_W-1:0] cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic              pending_q, pending_d;

    // Load on first arm or on REF, otherwise count down and stick at zero
    always_comb begin
        armed_d   = armed_q | arm_i;
        cnt_d     = (ref_i || (arm_i && !armed_q)) ? REFI_W'(T_REFI) :
                    (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        pending_d = armed_d && (cnt_d == '0);
    end

    // Counter, arm flag and pending flag registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/ddr3_cmd_scheduler.sv
// ddr3_cmd_scheduler: power-up, periodic refresh and ACT/RW/PRE sequencing; AUTO_PRECHARGE_EN selects RW with auto-precharge
module ddr3_cmd_scheduler
    import ddr3_sched_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    input  logic [BA_W-1:0]  req_ba,
    input  logic [DQ_W-1:0]  req_wdata,
    output logic             ZQCL,
    output logic             MRS,
    output logic             REF,
    output logic             ACT,
    output logic             WRITE,
    output logic             READ,
    output logic             PRE,
    output logic             WRITE_AP,
    output logic             READ_AP,
    output logic [ROW_W-1:0] Addr_Row,
    output logic [COL_W-1:0] Addr_Column,
    output logic [BA_W-1:0]  BA_out,
    output logic [DQ_W-1:0]  DQ_out,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [BA_W-1:0]  ba_q, ba_d;
    logic [DQ_W-1:0]  dq_q, dq_d;
    logic             wr_q, wr_d;
    logic             refresh_pending;
    logic             last;

    ddr3_refresh_timer u_refresh_timer (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .arm_i     (state_d == ST_IDLE),
        .ref_i     (state_q == ST_REFRESH),
        .pending_o (refresh_pending)
    );

    assign last      = cnt_q == CNT_W'(1);
    assign req_ready = (state_q == ST_IDLE) && !refresh_pending;

    // Next state, wait-counter loads and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        row_d   = row_q;
        col_d   = col_q;
        ba_d    = ba_q;
        dq_d    = dq_q;
        wr_d    = wr_q;
        case (state_q)
            ST_INIT_WAIT: state_d = last ? ST_ZQ : ST_INIT_WAIT;
            ST_ZQ: begin
                cnt_d   = ld(T_ZQ);
                state_d = ST_ZQ_WAIT;
            end
            ST_ZQ_WAIT:   state_d = last ? ST_MRS : ST_ZQ_WAIT;
            ST_MRS: begin
                cnt_d   = ld(T_MRD);
                state_d = ST_MRS_WAIT;
            end
            ST_MRS_WAIT:  state_d = last ? ST_IDLE : ST_MRS_WAIT;
            ST_IDLE: begin
                if (refresh_pending) begin
                    state_d = ST_REFRESH;
                end else if (req_valid) begin
                    state_d = ST_ACTIVATE;
                    row_d   = req_row;
                    col_d   = req_col;
                    ba_d    = req_ba;
                    dq_d    = req_wdata;
                    wr_d    = req_write;
                end
            end
            ST_REFRESH: begin
                cnt_d   = ld(T_RFC);
                state_d = ST_RFC_WAIT;
            end
            ST_RFC_WAIT:  state_d = last ? ST_IDLE : ST_RFC_WAIT;
            ST_ACTIVATE: begin
                cnt_d   = ld(T_RCD);
                state_d = ST_RCD_WAIT;
            end
            ST_RCD_WAIT:  state_d = last ? ST_RW : ST_RCD_WAIT;
            ST_RW: begin
`ifdef AUTO_PRECHARGE_EN
                cnt_d   = wr_q ? ld(T_WR + T_RP) : ld(T_RTP + T_RP);
`else
                cnt_d   = wr_q ? ld(T_WR) : ld(T_RTP);
`endif
                state_d = ST_RW_WAIT;
            end
`ifdef AUTO_PRECHARGE_EN
            ST_RW_WAIT:   state_d = last ? ST_IDLE : ST_RW_WAIT;
`else
            ST_RW_WAIT:   state_d = last ? ST_PRECHARGE : ST_RW_WAIT;
`endif
            ST_PRECHARGE: begin
                cnt_d   = ld(T_RP);
                state_d = ST_RP_WAIT;
            end
            ST_RP_WAIT:   state_d = last ? ST_IDLE : ST_RP_WAIT;
            default:      state_d = ST_INIT_WAIT;
        endcase
    end

    // State, wait counter and latched request fields
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_INIT_WAIT;
            cnt_q   <= CNT_W'(T_INIT);
            row_q   <= '0;
            col_q   <= '0;
            ba_q    <= '0;
            dq_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ba_q    <= ba_d;
            dq_q    <= dq_d;
            wr_q    <= wr_d;
        end
    end

    assign ZQCL  = state_q == ST_ZQ;
    assign MRS   = state_q == ST_MRS;
    assign REF   = state_q == ST_REFRESH;
    assign ACT   = state_q == ST_ACTIVATE;
    assign PRE   = state_q == ST_PRECHARGE;
`ifdef AUTO_PRECHARGE_EN
    assign WRITE    = 1'b0;
    assign READ     = 1'b0;
    assign WRITE_AP = (state_q == ST_RW) && wr_q;
    assign READ_AP  = (state_q == ST_RW) && !wr_q;
`else
    assign WRITE    = (state_q == ST_RW) && wr_q;
    assign READ     = (state_q == ST_RW) && !wr_q;
    assign WRITE_AP = 1'b0;
    assign READ_AP  = 1'b0;
`endif
    assign busy        = state_q != ST_IDLE;
    assign Addr_Row    = row_q;
    assign Addr_Column = col_q;
    assign BA_out      = ba_q;
    assign DQ_out      = dq_q;

endmodule

// File: tb/tb_ddr3_cmd_scheduler.sv
// tb_ddr3_cmd_scheduler: random traffic and resets checked against an event-schedule model of the command timeline
module tb_ddr3_cmd_scheduler;

    localparam int T_INIT = 8;
    localparam int T_ZQ   = 16;
    localparam int T_MRD  = 4;
    localparam int T_RCD  = 3;
    localparam int T_WR   = 6;
    localparam int T_RTP  = 4;
    localparam int T_RP   = 3;
    localparam int T_RFC  = 20;
    localparam int T_REFI = 200;

    localparam logic [8:0] S_ZQ  = 9'h100;
    localparam logic [8:0] S_MRS = 9'h080;
    localparam logic [8:0] S_REF = 9'h040;
    localparam logic [8:0] S_ACT = 9'h020;
    localparam logic [8:0] S_WR  = 9'h010;
    localparam logic [8:0] S_RD  = 9'h008;
    localparam logic [8:0] S_PRE = 9'h004;
    localparam logic [8:0] S_WAP = 9'h002;
    localparam logic [8:0] S_RAP = 9'h001;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [14:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic [2:0]  req_ba = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, ZQCL, MRS, REF, ACT, WRITE, READ, PRE, WRITE_AP, READ_AP, busy;
    logic [14:0] Addr_Row;
    logic [9:0]  Addr_Column;
    logic [2:0]  BA_out;
    logic [15:0] DQ_out;

    always #5 CLK = ~CLK;

    ddr3_cmd_scheduler dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_row     (req_row),
        .req_col     (req_col),
        .req_ba      (req_ba),
        .req_wdata   (req_wdata),
        .ZQCL        (ZQCL),
        .MRS         (MRS),
        .REF         (REF),
        .ACT         (ACT),
        .WRITE       (WRITE),
        .READ        (READ),
        .PRE         (PRE),
        .WRITE_AP    (WRITE_AP),
        .READ_AP     (READ_AP),
        .Addr_Row    (Addr_Row),
        .Addr_Column (Addr_Column),
        .BA_out      (BA_out),
        .DQ_out      (DQ_out),
        .busy        (busy)
    );

    int          cyc, free_at, ref_due, reset_at, n_chk, n_fail;
    logic [8:0]  sched [int];
    logic [14:0] e_row;
    logic [9:0]  e_col;
    logic [2:0]  e_ba;
    logic [15:0] e_dq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Power-up timeline starting with cycle b as the first cycle out of reset
    task automatic restart(input int b);
        sched.delete();
        sched[b + T_INIT]        = S_ZQ;
        sched[b + T_INIT + T_ZQ] = S_MRS;
        free_at = b + T_INIT + T_ZQ + T_MRD;
        ref_due = free_at + T_REFI;
        e_row = '0;
        e_col = '0;
        e_ba  = '0;
        e_dq  = '0;
    endtask

    // Schedule every command of an accepted transaction decided in cycle cyc
    task automatic accept();
        int rw;
        sched[cyc + 1] = S_ACT;
        rw = cyc + 1 + T_RCD;
`ifdef AUTO_PRECHARGE_EN
        sched[rw] = req_write ? S_WAP : S_RAP;
        free_at = rw + (req_write ? T_WR : T_RTP) + T_RP;
`else
        sched[rw] = req_write ? S_WR : S_RD;
        sched[rw + (req_write ? T_WR : T_RTP)] = S_PRE;
        free_at = rw + (req_write ? T_WR : T_RTP) + T_RP;
`endif
        e_row = req_row;
        e_col = req_col;
        e_ba  = req_ba;
        e_dq  = req_wdata;
    endtask

    initial begin
        logic [8:0] e_strb;
        logic       idle, pend;
        n_chk = 0;
        n_fail = 0;
        reset_at = -1;
        cyc = 0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        restart(0);
        for (int i = 0; i < 4000; i++) begin
            if (i > 0) begin
                @(posedge CLK);
                #1;
                cyc++;
            end
            e_strb = sched.exists(cyc) ? sched[cyc] : 9'h000;
            idle = cyc >= free_at;
            pend = cyc >= ref_due;
            check("strobes", {ZQCL, MRS, REF, ACT, WRITE, READ, PRE, WRITE_AP, READ_AP}, e_strb);
            check("req_ready", req_ready, idle && !pend);
            check("busy", busy, !idle);
            check("Addr_Row", Addr_Row, e_row);
            check("Addr_Column", Addr_Column, e_col);
            check("BA_out", BA_out, e_ba);
            check("DQ_out", DQ_out, e_dq);
            req_row   = 15'($urandom);
            req_col   = 10'($urandom);
            req_ba    = 3'($urandom);
            req_wdata = 16'($urandom);
            req_write = 1'($urandom);
            req_valid = 1'b0;
            if (cyc == 30) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_row   = 15'h5D6E;
                req_col   = 10'h7F8;
                req_ba    = 3'd2;
                req_wdata = 16'hA5A5;
            end else if (cyc >= 700) begin
                req_valid = $urandom_range(0, 2) == 0;
            end
            RESET = (cyc == reset_at) || (cyc > 1200 && $urandom_range(0, 999) == 0);
            if (RESET) begin
                restart(cyc + 1);
            end else if (idle) begin
                if (pend) begin
                    sched[cyc + 1] = S_REF;
                    free_at = cyc + 1 + T_RFC;
                    ref_due = cyc + 2 + T_REFI;
                end else if (req_valid) begin
                    accept();
                    if (reset_at < 0 && cyc >= 700) reset_at = cyc + 2;
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
